set_assoc_cache: RTL and testbench
==================================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameters: WAYS, default 2, ways per set, power of two, 1..8; INDEX_LENGTH, default 6, set-index bits; OFFSET_LENGTH, default 3, word-select bits (line = 2**OFFSET_LENGTH words); DATA_WIDTH, default 64, word width; ADDR_WIDTH, default 64, word-address width.
REQ-002 SHALL have ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- avalid, aready  in/out  1  CPU request handshake.
- aaddr  in  ADDR_WIDTH  word address.
- load  in  1  1 = load, 0 = store.
- data_from_cpu  in  DATA_WIDTH  store data.
- dvalid, dready  out/in  1  load-response handshake.
- data_to_cpu  out  DATA_WIDTH  load data.
- command_valid, command_store  out  1  bus command valid; 1 = writeback, 0 = refill.
- command_addr  out  ADDR_WIDTH  line-aligned address (offset bits 0).
- data_to_bus  out  DATA_WIDTH*2**OFFSET_LENGTH  writeback line.
- bus_ready  in  1  bus accepts command this cycle.
- bus_valid  in  1  refill line valid this cycle.
- data_from_bus  in  DATA_WIDTH*2**OFFSET_LENGTH  refill line.

Function
REQ-003 SHALL decode aaddr as tag = [ADDR_WIDTH-1:INDEX_LENGTH+OFFSET_LENGTH], index, offset = [OFFSET_LENGTH-1:0]; word k of a line occupies bits [(k+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-004 SHALL hold per way per set: valid, dirty, tag, line; per set a round-robin victim pointer of $clog2(WAYS) bits (0 bits when WAYS=1).
REQ-005 SHALL implement states IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT, RESP; one outstanding request; blocking.
REQ-006 IDLE: aready=1; avalid&&aready registers aaddr, load, data_from_cpu and goes to LOOKUP; aready=0 in every other state.
REQ-007 LOOKUP: hit = any valid way with matching tag (at most one). Load hit -> RESP, data_to_cpu = hit word. Store hit -> write word, set dirty, -> IDLE; no dvalid for stores.
REQ-008 Miss victim: lowest-numbered invalid way, else way at set pointer; pointer increments (mod WAYS) only when a valid way is evicted. Victim dirty -> WRITEBACK, else -> REFILL_REQ.
REQ-009 WRITEBACK: command_valid=1, command_store=1, command_addr={victim tag,index,0}, data_to_bus=victim line, all stable until bus_ready; then victim dirty cleared, -> REFILL_REQ.
REQ-010 REFILL_REQ: command_valid=1, command_store=0, command_addr={tag,index,0} until bus_ready, -> REFILL_WAIT; bus_valid outside REFILL_WAIT SHALL be ignored.
REQ-011 REFILL_WAIT: on bus_valid install data_from_bus in victim, valid=1, tag set; store: merged word written, dirty=1, -> IDLE; load: dirty=0, data_to_cpu = refilled word, -> RESP.
REQ-012 RESP: dvalid=1, data_to_cpu stable until dready, then -> IDLE; earliest next accept one cycle later (no IDLE bypass).
REQ-013 Latency: load hit 2 cycles accept-to-dvalid; clean miss 2 + bus cycles; store hit frees aready after 2 cycles.
REQ-014 command_valid, aready, dvalid SHALL decode from registered state only; data_to_bus SHALL be 0 when not in WRITEBACK.

Reset
REQ-015 reset_n low, at any time including mid-bus-transaction, SHALL force IDLE, clear all valid, dirty, pointers, captured request; outputs: aready=1, dvalid=0, command_valid=0, command_store=0, command_addr=0, data_to_cpu=0, data_to_bus=0. Aborted bus commands are not resumed.

Configuration
REQ-016 CACHE_STATS_EN defined: adds outputs hit_count, miss_count, writeback_count (32 bits each, saturating, reset 0), incremented once per LOOKUP hit, LOOKUP miss, WRITEBACK completion. Undefined: ports and counters absent; behaviour otherwise identical.

Structure
REQ-017 cache_pkg SHALL hold the state enum and command encodings (CMD_REFILL=0, CMD_WRITEBACK=1).
REQ-018 Sub-module line_merge SHALL replace one word of a line by offset (combinational); used for store hit and store-miss merge.

Verification (WAYS=2, INDEX_LENGTH=2, OFFSET_LENGTH=2, DATA_WIDTH=32, ADDR_WIDTH=16)
REQ-019 Load 0x0041 cold -> REFILL_REQ addr 0x0040; bus_valid line {4,3,2,1} (word3..0) -> dvalid, data_to_cpu=2.
REQ-020 Store 0x0042=0xAA then load 0x0042 -> hit, dvalid 2 cycles after accept, data 0xAA, no bus command.
REQ-021 Fill set 0 with tags at 0x0000, 0x0010 (dirty via store); load 0x0020 -> victim way 0 clean, no writeback; load 0x0030 -> WRITEBACK addr 0x0010 with stored line, then refill 0x0030.
REQ-022 Hold bus_ready=0 for 5 cycles in WRITEBACK -> command_addr/data_to_bus stable, aready=0 throughout.
REQ-023 Assert reset_n=0 during REFILL_WAIT -> command_valid=0 immediately, prior hit address now misses.
REQ-024 With CACHE_STATS_EN: scenarios REQ-019..021 -> hit_count, miss_count, writeback_count match event totals.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types for the set-associative cache: controller state codes, bus
// command encodings and a saturating-counter helper.
package cache_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_LOOKUP      = 3'd1;
  localparam state_t ST_WRITEBACK   = 3'd2;
  localparam state_t ST_REFILL_REQ  = 3'd3;
  localparam state_t ST_REFILL_WAIT = 3'd4;
  localparam state_t ST_RESP        = 3'd5;

  localparam logic CMD_REFILL    = 1'b0;
  localparam logic CMD_WRITEBACK = 1'b1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/set_assoc_cache_if.sv
// CPU request/response and memory-bus signals of the cache. The cache takes
// the slave view; the requester/bus side takes the master view.
interface set_assoc_cache_if #(
  parameter int ADDR_WIDTH    = 64,
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 3
);
  localparam int LINE_W = DATA_WIDTH * (2 ** OFFSET_LENGTH);

  logic                  avalid, aready;
  logic [ADDR_WIDTH-1:0] aaddr;
  logic                  load;
  logic [DATA_WIDTH-1:0] data_from_cpu;
  logic                  dvalid, dready;
  logic [DATA_WIDTH-1:0] data_to_cpu;
  logic                  command_valid, command_store;
  logic [ADDR_WIDTH-1:0] command_addr;
  logic [LINE_W-1:0]     data_to_bus;
  logic                  bus_ready, bus_valid;
  logic [LINE_W-1:0]     data_from_bus;

  modport slave (
    input  avalid, aaddr, load, data_from_cpu, dready, bus_ready, bus_valid, data_from_bus,
    output aready, dvalid, data_to_cpu, command_valid, command_store, command_addr, data_to_bus
  );

  modport master (
    output avalid, aaddr, load, data_from_cpu, dready, bus_ready, bus_valid, data_from_bus,
    input  aready, dvalid, data_to_cpu, command_valid, command_store, command_addr, data_to_bus
  );
endinterface

// File: rtl/line_merge.sv
// Replaces the word selected by offset within a cache line; purely combinational.
module line_merge #(
  parameter int DATA_WIDTH    = 64,
  parameter int OFFSET_LENGTH = 3,
  parameter int LINE_W        = DATA_WIDTH * (2 ** OFFSET_LENGTH)
) (
  input  logic [LINE_W-1:0]        line_in,
  input  logic [OFFSET_LENGTH-1:0] offset,
  input  logic [DATA_WIDTH-1:0]    word,
  output logic [LINE_W-1:0]        line_out
);
  localparam int WORDS = 2 ** OFFSET_LENGTH;

  for (genvar k = 0; k < WORDS; k++) begin : g_word
    assign line_out[k*DATA_WIDTH +: DATA_WIDTH] =
      (offset == OFFSET_LENGTH'(k)) ? word : line_in[k*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule

// File: rtl/set_assoc_cache.sv
// Blocking write-back, write-allocate set-associative cache with round-robin
// replacement. Define CACHE_STATS_EN to add hit/miss/writeback counters.
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int WAYS          = 2,
  parameter int INDEX_LENGTH  = 6,
  parameter int OFFSET_LENGTH = 3,
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 64
) (
  input logic clk,
  input logic reset_n,
  set_assoc_cache_if.slave io
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] writeback_count
`endif
);
  localparam int SETS   = 2 ** INDEX_LENGTH;
  localparam int WORDS  = 2 ** OFFSET_LENGTH;
  localparam int LINE_W = DATA_WIDTH * WORDS;
  localparam int TAG_W  = ADDR_WIDTH - INDEX_LENGTH - OFFSET_LENGTH;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  req_load_q, req_load_d;
  logic [DATA_WIDTH-1:0] req_data_q, req_data_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [SETS-1:0][WAYS-1:0]  valid_q, dirty_q;
  logic [SETS-1:0][WAY_W-1:0] ptr_q;
  logic [TAG_W-1:0]           tag_q  [SETS][WAYS];
  logic [LINE_W-1:0]          line_q [SETS][WAYS];

  logic [TAG_W-1:0]         req_tag;
  logic [INDEX_LENGTH-1:0]  req_idx;
  logic [OFFSET_LENGTH-1:0] req_off;
  assign req_tag = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx = req_addr_q[OFFSET_LENGTH +: INDEX_LENGTH];
  assign req_off = req_addr_q[OFFSET_LENGTH-1:0];

  logic             hit, all_valid;
  logic [WAY_W-1:0] hit_way, victim_sel;

  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_sel = ptr_q[req_idx];
    all_valid  = &valid_q[req_idx];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Descending scan leaves the lowest-numbered invalid way selected.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim_sel = WAY_W'(w);
    end
  end

  logic [LINE_W-1:0]     hit_line, victim_line, merge_src, merged_line;
  logic [TAG_W-1:0]      victim_tag;
  logic [DATA_WIDTH-1:0] hit_word, bus_word;

  assign hit_line    = line_q[req_idx][hit_way];
  assign victim_line = line_q[req_idx][victim_q];
  assign victim_tag  = tag_q[req_idx][victim_q];
  assign hit_word    = hit_line[req_off*DATA_WIDTH +: DATA_WIDTH];
  assign bus_word    = io.data_from_bus[req_off*DATA_WIDTH +: DATA_WIDTH];
  assign merge_src   = (state_q == ST_REFILL_WAIT) ? io.data_from_bus : hit_line;

  line_merge #(
    .DATA_WIDTH(DATA_WIDTH), .OFFSET_LENGTH(OFFSET_LENGTH), .LINE_W(LINE_W)
  ) u_merge (
    .line_in(merge_src), .offset(req_off), .word(req_data_q), .line_out(merged_line)
  );

  logic              line_we, line_dirty, clr_dirty, ptr_adv;
  logic [WAY_W-1:0]  line_way;
  logic [LINE_W-1:0] line_wdata;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_load_d = req_load_q;
    req_data_d = req_data_q;
    victim_d   = victim_q;
    rdata_d    = rdata_q;
    line_we    = 1'b0;
    line_way   = victim_q;
    line_wdata = merged_line;
    line_dirty = 1'b0;
    clr_dirty  = 1'b0;
    ptr_adv    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (io.avalid) begin
        req_addr_d = io.aaddr;
        req_load_d = io.load;
        req_data_d = io.data_from_cpu;
        state_d    = ST_LOOKUP;
      end
      ST_LOOKUP: if (hit) begin
        if (req_load_q) begin
          rdata_d = hit_word;
          state_d = ST_RESP;
        end else begin
          line_we    = 1'b1;
          line_way   = hit_way;
          line_dirty = 1'b1;
          state_d    = ST_IDLE;
        end
      end else begin
        victim_d = victim_sel;
        ptr_adv  = all_valid;
        state_d  = (all_valid && dirty_q[req_idx][victim_sel]) ? ST_WRITEBACK : ST_REFILL_REQ;
      end
      ST_WRITEBACK: if (io.bus_ready) begin
        clr_dirty = 1'b1;
        state_d   = ST_REFILL_REQ;
      end
      ST_REFILL_REQ: if (io.bus_ready) state_d = ST_REFILL_WAIT;
      ST_REFILL_WAIT: if (io.bus_valid) begin
        line_we    = 1'b1;
        line_wdata = req_load_q ? io.data_from_bus : merged_line;
        line_dirty = !req_load_q;
        if (req_load_q) begin
          rdata_d = bus_word;
          state_d = ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: if (io.dready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_addr_q <= '0;
      req_load_q <= 1'b0;
      req_data_q <= '0;
      victim_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_load_q <= req_load_d;
      req_data_q <= req_data_d;
      victim_q   <= victim_d;
      rdata_q    <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
      ptr_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          line_q[s][w] <= '0;
        end
      end
    end else begin
      if (line_we) begin
        line_q[req_idx][line_way]  <= line_wdata;
        tag_q[req_idx][line_way]   <= req_tag;
        valid_q[req_idx][line_way] <= 1'b1;
        dirty_q[req_idx][line_way] <= line_dirty;
      end
      if (clr_dirty) dirty_q[req_idx][victim_q] <= 1'b0;
      if (ptr_adv) ptr_q[req_idx] <= (WAYS == 1) ? '0 : ptr_q[req_idx] + WAY_W'(1);
    end
  end

  assign io.aready        = (state_q == ST_IDLE);
  assign io.dvalid        = (state_q == ST_RESP);
  assign io.command_valid = (state_q == ST_WRITEBACK) || (state_q == ST_REFILL_REQ);
  assign io.command_store = (state_q == ST_WRITEBACK) ? CMD_WRITEBACK : CMD_REFILL;
  assign io.command_addr  =
    (state_q == ST_WRITEBACK)  ? {victim_tag, req_idx, {OFFSET_LENGTH{1'b0}}} :
    (state_q == ST_REFILL_REQ) ? {req_tag,    req_idx, {OFFSET_LENGTH{1'b0}}} : '0;
  assign io.data_to_bus   = (state_q == ST_WRITEBACK) ? victim_line : '0;
  assign io.data_to_cpu   = rdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = sat_inc(hit_cnt_q,  (state_q == ST_LOOKUP) && hit);
    miss_cnt_d = sat_inc(miss_cnt_q, (state_q == ST_LOOKUP) && !hit);
    wb_cnt_d   = sat_inc(wb_cnt_q,   (state_q == ST_WRITEBACK) && io.bus_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_count       = hit_cnt_q;
  assign miss_count      = miss_cnt_q;
  assign writeback_count = wb_cnt_q;
`endif
endmodule

// File: tb/tb_set_assoc_cache.sv
// Bench for set_assoc_cache: directed scenarios plus random traffic checked
// against a tag-store model and an architectural memory image.
module tb_set_assoc_cache;
  localparam int AW = 16, DW = 32, OL = 2, IL = 2, WAYS = 2, SETS = 4;
  localparam int LW = DW * (2 ** OL);

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  set_assoc_cache_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_LENGTH(OL)) io ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, writeback_count;
`endif

  set_assoc_cache #(
    .WAYS(WAYS), .INDEX_LENGTH(IL), .OFFSET_LENGTH(OL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .io(io)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count),
    .writeback_count(writeback_count)
`endif
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: per-set way table, replacement pointers, bus memory and the
  // value each word architecturally holds.
  typedef struct { bit v; bit d; int tag; } mway_t;
  mway_t mset [SETS][WAYS];
  int mptr [SETS];
  logic [DW-1:0] bus_mem [int];
  logic [DW-1:0] shadow [int];
  int n_hit, n_miss, n_wb;

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] t;
    t = 32'(a);
    return (t * 32'd40503) ^ 32'hC0FF_EE00;
  endfunction

  function automatic logic [DW-1:0] bus_rd(input int a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] arch_rd(input int a);
    return shadow.exists(a) ? shadow[a] : bus_rd(a);
  endfunction

  function automatic logic [LW-1:0] line_of(input int base, input bit from_bus);
    logic [LW-1:0] l;
    for (int k = 0; k < 4; k++) l[k*DW +: DW] = from_bus ? bus_rd(base + k) : arch_rd(base + k);
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < WAYS; w++) mset[s][w] = '{v: 1'b0, d: 1'b0, tag: 0};
    end
    // Dirty data dies with the reset; memory is what remains.
    shadow.delete();
    foreach (bus_mem[a]) shadow[a] = bus_mem[a];
    n_hit = 0; n_miss = 0; n_wb = 0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_aready"}, io.aready, 1);
    chk({pfx, "_dvalid"}, io.dvalid, 0);
    chk({pfx, "_cmd_valid"}, io.command_valid, 0);
    chk({pfx, "_cmd_store"}, io.command_store, 0);
    chk({pfx, "_cmd_addr"}, io.command_addr, 0);
    chk({pfx, "_data_to_cpu"}, io.data_to_cpu, 0);
    chk({pfx, "_data_to_bus"}, io.data_to_bus, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    io.avalid = 1'b0; io.dready = 1'b0; io.bus_ready = 1'b0; io.bus_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    model_reset();
  endtask

  // One CPU request, driven from a negedge while the cache is idle; returns on
  // the negedge where aready is seen again. wb_hold<0 picks a random stall.
  task automatic do_req(input int addr, input bit ld, input logic [DW-1:0] wd,
                        input int wb_hold, input bit abort);
    int set, tag, n, vw, hold, wait_cnt, phase, wb_addr, rf_addr;
    bit hit, evict_valid, exp_wb, wb_left, cmd_active, resp_seen, done, aborted;
    logic [DW-1:0] exp_rd, resp_data;
    logic [AW-1:0] cap_addr;
    logic [LW-1:0] cap_data;
    set = (addr >> OL) & (SETS - 1);
    tag = addr >> (OL + IL);
    rf_addr = addr & ~3;
    hit = 0; evict_valid = 0; exp_wb = 0; wb_addr = 0; vw = -1;
    for (int w = 0; w < WAYS; w++) if (mset[set][w].v && mset[set][w].tag == tag) hit = 1;
    if (!hit) begin
      for (int w = WAYS - 1; w >= 0; w--) if (!mset[set][w].v) vw = w;
      if (vw < 0) begin evict_valid = 1; vw = mptr[set]; end
      exp_wb = evict_valid && mset[set][vw].d;
      wb_addr = (mset[set][vw].tag << (OL + IL)) | (set << OL);
    end
    exp_rd = arch_rd(addr);
    if (hit) n_hit++; else n_miss++;
    if (exp_wb) n_wb++;
    wb_left = exp_wb; cmd_active = 0; resp_seen = 0; done = 0; aborted = 0;
    phase = 0; hold = 0; wait_cnt = 0; resp_data = '0; cap_addr = '0; cap_data = '0;

    chk("aready_idle", io.aready, 1);
    io.avalid = 1'b1; io.aaddr = AW'(addr); io.load = ld; io.data_from_cpu = wd;
    @(negedge clk);
    io.avalid = 1'b0; io.aaddr = AW'($urandom); io.data_from_cpu = $urandom;
    n = 1;
    while (!done && n < 100) begin
      io.bus_ready = 1'b0; io.dready = 1'b0; io.bus_valid = 1'b0;
      io.data_from_bus = {$urandom, $urandom, $urandom, $urandom};
      if (phase != 1 && $urandom_range(0, 2) == 0) io.bus_valid = 1'b1;
      if (!(io.command_valid && io.command_store)) chk("bus_data_idle", io.data_to_bus, 0);
      if (io.aready) begin
        done = 1;
      end else if (io.command_valid) begin
        if (!cmd_active) begin
          cmd_active = 1;
          if (hit) chk("cmd_on_hit", io.command_valid, 0);
          chk("cmd_store", io.command_store, wb_left);
          chk("cmd_addr", io.command_addr, wb_left ? wb_addr : rf_addr);
          if (wb_left) chk("wb_line", io.data_to_bus, line_of(wb_addr, 0));
          cap_addr = io.command_addr;
          cap_data = io.data_to_bus;
          hold = (wb_left && wb_hold >= 0) ? wb_hold : $urandom_range(0, 2);
        end else begin
          chk("cmd_addr_stable", io.command_addr, cap_addr);
          chk("bus_data_stable", io.data_to_bus, cap_data);
        end
        if (hold == 0) begin
          io.bus_ready = 1'b1;
          cmd_active = 0;
          if (io.command_store) begin
            for (int k = 0; k < 4; k++) bus_mem[int'(io.command_addr) + k] = io.data_to_bus[k*DW +: DW];
            wb_left = 0;
          end else begin
            phase = 1;
            wait_cnt = $urandom_range(0, 3);
          end
        end else begin
          hold--;
        end
      end else if (phase == 1) begin
        if (abort) begin
          reset_n = 1'b0;
          #1;
          chk_reset_outputs("abort");
          @(negedge clk);
          reset_n = 1'b1;
          model_reset();
          done = 1; aborted = 1;
        end else if (wait_cnt == 0) begin
          io.bus_valid = 1'b1;
          io.data_from_bus = line_of(rf_addr, 1);
          phase = 2;
        end else begin
          wait_cnt--;
        end
      end
      if (!done && io.dvalid) begin
        if (!resp_seen) begin
          resp_seen = 1;
          resp_data = io.data_to_cpu;
          chk("load_data", io.data_to_cpu, exp_rd);
          if (hit) chk("load_hit_latency", n, 2);
        end else begin
          chk("resp_data_stable", io.data_to_cpu, resp_data);
        end
        if ($urandom_range(0, 1) == 1) io.dready = 1'b1;
      end
      if (!done) begin
        @(negedge clk);
        n++;
      end
    end
    chk("req_done", done, 1);
    if (!aborted) begin
      chk("resp_seen", resp_seen, ld);
      if (hit && !ld) chk("store_hit_free", n, 2);
      if (!ld) shadow[addr] = wd;
      if (hit) begin
        if (!ld) for (int w = 0; w < WAYS; w++)
          if (mset[set][w].v && mset[set][w].tag == tag) mset[set][w].d = 1;
      end else begin
        if (evict_valid) mptr[set] = (mptr[set] + 1) % WAYS;
        mset[set][vw] = '{v: 1'b1, d: !ld, tag: tag};
      end
    end
  endtask

  initial begin
    io.avalid = 1'b0; io.aaddr = '0; io.load = 1'b0; io.data_from_cpu = '0;
    io.dready = 1'b0; io.bus_ready = 1'b0; io.bus_valid = 1'b0; io.data_from_bus = '0;
    for (int k = 0; k < 4; k++) bus_mem[32'h40 + k] = DW'(k + 1);
    do_reset();

    // Cold load, then store/load hits on the same line.
    do_req(32'h0041, 1, '0, -1, 0);
    do_req(32'h0042, 0, 32'h0000_00AA, -1, 0);
    do_req(32'h0042, 1, '0, -1, 0);

    // Fill set 0, evict clean way 0, then dirty way 1 with a stalled writeback.
    do_reset();
    do_req(32'h0000, 1, '0, -1, 0);
    do_req(32'h0011, 0, 32'h1234_5678, -1, 0);
    do_req(32'h0020, 1, '0, -1, 0);
    do_req(32'h0031, 1, '0, 5, 0);
    do_req(32'h0013, 1, '0, -1, 0);

    // Reset while waiting on a refill; a previously hitting line must miss.
    do_req(32'h0020, 1, '0, -1, 0);
    do_req(32'h0104, 1, '0, -1, 1);
    do_req(32'h0020, 1, '0, -1, 0);

    for (int i = 0; i < 60; i++)
      do_req($urandom_range(0, 95), 1'($urandom_range(0, 1)), $urandom, -1, 0);

`ifdef CACHE_STATS_EN
    @(negedge clk);
    chk("hit_count", hit_count, n_hit);
    chk("miss_count", miss_count, n_miss);
    chk("writeback_count", writeback_count, n_wb);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
